// File: rtl/ttt_board_writer_if.sv
// Move-entry handshake between a move source and the board writer.
interface ttt_board_writer_if;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       move_ack;
    logic       move_err;

    modport master (output move_valid, move_pos, input move_ready, move_ack, move_err);
    modport slave  (input move_valid, move_pos, output move_ready, move_ack, move_err);
endinterface

// File: rtl/ttt_board_writer.sv
// Tic-tac-toe board writer: accepts moves, alternates turns, evaluates the
// eight lines after each write and latches win/draw status until a new game.
module ttt_board_writer #(
    parameter logic [1:0]  FIRST_PLAYER = 2'b01,
    parameter int unsigned TIMEOUT      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 new_game,
    ttt_board_writer_if.slave    mv,
    output logic [17:0]          board,
    output logic [1:0]           turn,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic                 forfeit
);
    typedef enum logic [1:0] {WAIT, CHECK, OVER} state_t;

    localparam logic [15:0] TLAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] timer;
    logic        ready_q, ack_q, err_q;
    logic        hs, legal;
    logic [1:0]  win;

    assign mv.move_ready = ready_q;
    assign mv.move_ack   = ack_q;
    assign mv.move_err   = err_q;

    function automatic logic same3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (b == c);
    endfunction

    function automatic logic [1:0] find_win(input logic [17:0] b);
        logic [1:0] c [9];
        logic [1:0] w;
        for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
        w = 2'b00;
        if (same3(c[0], c[1], c[2])) w = c[0];
        if (same3(c[3], c[4], c[5])) w = c[3];
        if (same3(c[6], c[7], c[8])) w = c[6];
        if (same3(c[0], c[3], c[6])) w = c[0];
        if (same3(c[1], c[4], c[7])) w = c[1];
        if (same3(c[2], c[5], c[8])) w = c[2];
        if (same3(c[0], c[4], c[8])) w = c[0];
        if (same3(c[2], c[4], c[6])) w = c[2];
        return w;
    endfunction

    // Out-of-range positions read back as a non-empty cell so they fail legality.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] pos);
        logic [1:0] r;
        r = 2'b11;
        for (int i = 0; i < 9; i++)
            if (pos == 4'(i)) r = b[2*i +: 2];
        return r;
    endfunction

    assign hs    = mv.move_valid & ready_q;
    assign legal = (cell_at(board, mv.move_pos) == 2'b00);
    assign win   = find_win(board);

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            state     <= WAIT;
            board     <= '0;
            turn      <= FIRST_PLAYER;
            cnt       <= '0;
            timer     <= '0;
            game_over <= 1'b0;
            winner    <= 2'b00;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            forfeit   <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            forfeit <= 1'b0;
            case (state)
                WAIT: begin
                    if (hs) begin
                        timer <= '0;
                        if (legal) begin
                            for (int i = 0; i < 9; i++)
                                if (mv.move_pos == 4'(i)) board[2*i +: 2] <= turn;
                            cnt     <= (cnt == 4'd9) ? cnt : cnt + 4'd1;
                            ack_q   <= 1'b1;
                            ready_q <= 1'b0;
                            state   <= CHECK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (TIMEOUT != 0) begin
                        if (timer == TLAST) begin
                            forfeit <= 1'b1;
                            turn    <= turn ^ 2'b11;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                CHECK: begin
                    // A completed line outranks the draw check on the ninth move.
                    if (win != 2'b00) begin
                        winner    <= win;
                        game_over <= 1'b1;
                        turn      <= 2'b00;
                        state     <= OVER;
                    end else if (cnt == 4'd9) begin
                        winner    <= 2'b00;
                        game_over <= 1'b1;
                        turn      <= 2'b00;
                        state     <= OVER;
                    end else begin
                        turn    <= turn ^ 2'b11;
                        timer   <= '0;
                        ready_q <= 1'b1;
                        state   <= WAIT;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ttt_board_writer.sv
// Directed bench for ttt_board_writer: one instance with the move timer off,
// one with TIMEOUT=4 for the forfeit behaviour.
module tb_ttt_board_writer;
    logic clk = 1'b0;
    logic rst_n, new_game;
    logic [17:0] board0, board1;
    logic [1:0]  turn0, turn1, winner0, winner1;
    logic        over0, over1, forf0, forf1;
    int n_cmp = 0;
    int n_mis = 0;
    int ack_cnt = 0;

    ttt_board_writer_if if0 ();
    ttt_board_writer_if if1 ();

    ttt_board_writer #(.FIRST_PLAYER(2'b01), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .mv(if0),
        .board(board0), .turn(turn0), .game_over(over0), .winner(winner0), .forfeit(forf0));

    ttt_board_writer #(.FIRST_PLAYER(2'b01), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .mv(if1),
        .board(board1), .turn(turn1), .game_over(over1), .winner(winner1), .forfeit(forf1));

    always #5 clk = ~clk;

    always @(negedge clk) if (if0.move_ack) ack_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a move on dut0 for one edge; on acceptance also step through CHECK.
    task automatic move0(input logic [3:0] p, input logic ok);
        if0.move_valid = 1'b1;
        if0.move_pos   = p;
        tick();
        if0.move_valid = 1'b0;
        chk("move_ack", 32'(if0.move_ack), 32'(ok));
        chk("move_err", 32'(if0.move_err), 32'(!ok));
        if (ok) tick();
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    int seq_win[5]  = '{0, 3, 1, 4, 2};
    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_last[9] = '{2, 0, 3, 1, 5, 4, 7, 6, 8};

    initial begin
        rst_n = 1'b0; new_game = 1'b0;
        if0.move_valid = 1'b0; if0.move_pos = '0;
        if1.move_valid = 1'b0; if1.move_pos = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_board", 32'(board0), 32'h0);
        chk("rst_turn",  32'(turn0),  32'h1);
        chk("rst_ready", 32'(if0.move_ready), 32'h1);
        chk("rst_over",  32'(over0),  32'h0);
        chk("rst_winner",32'(winner0),32'h0);
        chk("rst_pulses",32'({if0.move_ack, if0.move_err, forf0}), 32'h0);

        // timeout: three idle edges are quiet, the fourth forfeits
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_noforf", 32'(forf1), 32'h0);
            chk("to_turn",   32'(turn1), 32'h1);
        end
        tick();
        chk("to_forf",      32'(forf1),  32'h1);
        chk("to_turnflip",  32'(turn1),  32'h2);
        chk("to_board",     32'(board1), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_noforf2", 32'(forf1), 32'h0);
        end
        if1.move_valid = 1'b1; if1.move_pos = 4'd4;
        tick();
        if1.move_valid = 1'b0;
        chk("to_hs_ack",    32'(if1.move_ack), 32'h1);
        chk("to_hs_noforf", 32'(forf1), 32'h0);
        chk("to_hs_board",  32'(board1), 32'h200);
        tick();
        chk("to_hs_turn",   32'(turn1), 32'h1);
        chk("to_hs_forf2",  32'(forf1), 32'h0);

        // P1 wins on the top row
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            move0(4'(seq_win[i]), 1'b1);
            if (i < 4) chk("win_turn", 32'(turn0), (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        chk("win_over",   32'(over0),   32'h1);
        chk("win_winner", 32'(winner0), 32'h1);
        chk("win_board",  32'(board0),  32'h295);
        chk("win_turn0",  32'(turn0),   32'h0);
        chk("win_ready",  32'(if0.move_ready), 32'h0);
        chk("win_acks",   32'(ack_cnt), 32'd5);

        // moves are ignored silently once the game is over
        if0.move_valid = 1'b1; if0.move_pos = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("over_ready", 32'(if0.move_ready), 32'h0);
            chk("over_ack",   32'(if0.move_ack),   32'h0);
            chk("over_err",   32'(if0.move_err),   32'h0);
        end
        if0.move_valid = 1'b0;
        chk("over_board", 32'(board0), 32'h295);
        chk("over_hold",  32'(over0),  32'h1);

        pulse_new_game();
        chk("ng_board", 32'(board0), 32'h0);
        chk("ng_turn",  32'(turn0),  32'h1);
        chk("ng_ready", 32'(if0.move_ready), 32'h1);
        chk("ng_over",  32'(over0),  32'h0);

        // illegal moves: occupied cell and out-of-range position
        move0(4'd4, 1'b1);
        chk("ill_turn0", 32'(turn0), 32'h2);
        move0(4'd4, 1'b0);
        chk("ill_occ_board", 32'(board0), 32'h100);
        chk("ill_occ_turn",  32'(turn0),  32'h2);
        move0(4'd9, 1'b0);
        chk("ill_rng_board", 32'(board0), 32'h100);
        chk("ill_rng_turn",  32'(turn0),  32'h2);

        // new_game beats a simultaneous move
        new_game = 1'b1; if0.move_valid = 1'b1; if0.move_pos = 4'd0;
        tick();
        new_game = 1'b0; if0.move_valid = 1'b0;
        chk("ngmv_ack",   32'(if0.move_ack), 32'h0);
        chk("ngmv_err",   32'(if0.move_err), 32'h0);
        chk("ngmv_board", 32'(board0), 32'h0);
        chk("ngmv_turn",  32'(turn0),  32'h1);
        move0(4'd0, 1'b1);
        chk("pre_rst_board", 32'(board0), 32'h1);
        rst_n = 1'b0; if0.move_valid = 1'b1; if0.move_pos = 4'd5;
        tick();
        if0.move_valid = 1'b0;
        chk("rstmv_ack",   32'(if0.move_ack), 32'h0);
        chk("rstmv_board", 32'(board0), 32'h0);
        chk("rstmv_turn",  32'(turn0),  32'h1);
        chk("rstmv_ready", 32'(if0.move_ready), 32'h1);
        rst_n = 1'b1;

        // draw after nine moves
        for (int i = 0; i < 9; i++) begin
            move0(4'(seq_draw[i]), 1'b1);
            if (i == 7) chk("draw_pre_over", 32'(over0), 32'h0);
        end
        chk("draw_over",   32'(over0),   32'h1);
        chk("draw_winner", 32'(winner0), 32'h0);
        chk("draw_turn",   32'(turn0),   32'h0);
        chk("draw_board",  32'(board0),  32'h16A59);

        // ninth move completes a column: winner, not draw
        pulse_new_game();
        for (int i = 0; i < 9; i++) begin
            move0(4'(seq_last[i]), 1'b1);
            if (i == 7) chk("last_pre_over", 32'(over0), 32'h0);
        end
        chk("last_over",   32'(over0),   32'h1);
        chk("last_winner", 32'(winner0), 32'h1);
        chk("last_board",  32'(board0),  32'h1665A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/ttt_board_writer.md
Name: ttt_board_writer

Overview:
Move-entry and board-state controller for the tic-tac-toe design. It accepts player moves over a valid/ready handshake and writes them into the 9-cell, 2-bit-per-cell board register. It alternates turns, rejects illegal moves, and evaluates all 8 lines after each write. It sets game-over status with the winning player, or a draw. It is the writer side of the board encoding that the line-winner checks consume.

Parameters:
FIRST_PLAYER, 2'b01, code of the player who moves first after reset/new game (legal: 2'b01 or 2'b10).
TIMEOUT, 0, cycles to wait for a move before the turn is forfeited; 0 disables the timer (max 65535).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
new_game  input  1  synchronous clear of board/state, same effect as reset
move_valid  input  1  move request
move_pos  input  4  cell index 0..8 (row-major; 0 = top-left)
move_ready  output  1  high when a move can be accepted
move_ack  output  1  1-cycle pulse: move written
move_err  output  1  1-cycle pulse: move rejected
board  output  18  cell i at board[2i+1:2i]; 00 empty, 01 player 1, 10 player 2
turn  output  2  code of the player to move (00 when game over)
game_over  output  1  level, high until reset/new_game
winner  output  2  winning player code; 00 on draw or game in progress
forfeit  output  1  1-cycle pulse: turn passed on timeout

Behaviour:
- Reset (rst_n low at edge) and new_game: board = 0, turn = FIRST_PLAYER, state = WAIT, move counter = 0, timer = 0, game_over = 0, winner = 00, move_ready = 1 the next cycle, all pulses = 0. rst_n has priority over everything; new_game has priority over move_valid in the same cycle (the move is dropped, with no ack and no err).
- States: WAIT, CHECK, OVER.
- WAIT: move_ready = 1. A handshake is move_valid & move_ready at an edge.
  - Legal move (move_pos <= 8 and cell == 00): at that edge, board cell <= turn, counter += 1, move_ack pulses next cycle, state -> CHECK.
  - Illegal move (move_pos > 8 or cell occupied): move_err pulses next cycle, board/turn unchanged, state stays WAIT, timer restarts.
- CHECK (exactly one cycle, move_ready = 0): evaluates 8 lines (3 rows, 3 columns, 2 diagonals). A line wins iff all three cells are equal on both bits and the cell is non-zero.
  - Win: winner <= that code, game_over <= 1, turn <= 00, state -> OVER.
  - Else if counter == 9: draw, so game_over <= 1, winner <= 00, turn <= 00, state -> OVER.
  - Else: turn <= other player, state -> WAIT.
  - A win on the 9th move reports the winner, not a draw.
- Latency: handshake at edge T; board updated and move_ack high after T; status (game_over/winner/turn) valid after T+1.
- OVER: move_ready = 0. move_valid is ignored with no err. The state is held until rst_n or new_game.
- Timer (TIMEOUT > 0): counts in WAIT only; clears on any handshake or on entering WAIT. When it reaches TIMEOUT-1 with no handshake, forfeit pulses next cycle, turn flips, the timer clears, and the board is unchanged. A handshake in the same cycle the timeout is reached takes priority (no forfeit).
- move_pos is sampled only on a handshake. Widths are fixed; the counter is 4 bits and saturates at 9.

Test Plan:
1. Reset, then moves by P1/P2 at 0,3,1,4,2 -> after the 5th move + 1 cycle: game_over=1, winner=01, board=18'h00_0_bits with cells 0-2 = 01 and 3,4 = 10, turn=00; move_ack pulses 5 times.
2. P1 plays 4, P2 plays 4 -> move_err pulse, board cell 4 stays 01, turn stays 10. Then move_pos=9 -> move_err, no change.
3. Full draw sequence 0,1,2,4,3,5,7,6,8 -> after the 9th move: game_over=1, winner=00; the 9th move that completes a line (variant sequence) reports winner, not draw.
4. TIMEOUT=4: after reset, hold move_valid=0 for 4 cycles -> forfeit pulse, turn 01->10, board 0. Then a handshake on the terminal cycle -> no forfeit.
5. Mid-game, assert new_game together with move_valid -> board=0, turn=FIRST_PLAYER, no ack/err. Repeat with rst_n=0 -> same clear at the edge.
6. In OVER, drive move_valid=1 for 3 cycles -> move_ready=0, no ack/err, board unchanged.
